vx_stream_rsp_tracker: RTL and testbench
========================================

// Module: VX_stream_rsp_tracker
// PURPOSE
//  Per-output request/response tracker on the downstream side of a stream crossbar output port.
//  - Forwards requests to the target (e.g. a memory bank).
//  - Records the crossbar's originating-input index (sel) of each accepted request in an in-order tag queue.
//  - Tags each returning in-order response with that index, so the return crossbar routes it back to the requester.
//  - Bounds outstanding requests to MAX_PENDING.
// PARAMETERS
//  NUM_INPUTS   4                      crossbar input count (requesters)
//  IN_WIDTH     `LOG2UP(NUM_INPUTS)    width of sel index
//  REQ_DATAW    4                      request payload width
//  RSP_DATAW    4                      response payload width
//  MAX_PENDING  4                      tag queue depth; power of 2, >= 2
//  LUTRAM       0                      1: tag storage in LUTRAM
// PORTS
//  clk            in   1                   clock
//  reset          in   1                   synchronous, active-high reset
//  req_valid_in   in   1                   request from crossbar output
//  req_data_in    in   REQ_DATAW           request payload
//  req_sel_in     in   IN_WIDTH            originating input index
//  req_ready_in   out  1                   request accepted
//  req_valid_out  out  1                   request to target
//  req_data_out   out  REQ_DATAW           request payload to target
//  req_ready_out  in   1                   target ready
//  rsp_valid_in   in   1                   response from target, in request order
//  rsp_data_in    in   RSP_DATAW           response payload
//  rsp_ready_in   out  1                   response accepted
//  rsp_valid_out  out  1                   tagged response to return crossbar
//  rsp_data_out   out  RSP_DATAW           response payload
//  rsp_sel_out    out  IN_WIDTH            destination input index
//  rsp_ready_out  in   1                   return crossbar ready
//  pending        out  CLOG2(MAX_PENDING+1) outstanding request count
//  rsp_error      out  1                   sticky: response arrived with empty tag queue
// BEHAVIOUR
//  - Reset (sync, active-high): queue empty, pending=0, rsp_error=0, rd/wr pointers=0.
//    Every valid/ready output is 0 while reset is high.
//  - Request path: combinational, zero latency.
//    - req_valid_out = req_valid_in & ~full
//    - req_ready_in  = req_ready_out & ~full
//    - req_data_out  = req_data_in
//  - Push: req_fire = req_valid_in & req_ready_in pushes req_sel_in at wr_ptr on the clock edge.
//  - Full blocks requests even if a pop occurs in the same cycle. No full-bypass: no ready-to-ready comb path.
//  - Response path: combinational, zero latency.
//    - rsp_valid_out = rsp_valid_in & ~empty
//    - rsp_ready_in  = rsp_ready_out & ~empty
//    - rsp_data_out  = rsp_data_in
//    - rsp_sel_out   = tag at rd_ptr (head)
//  - Pop: rsp_fire = rsp_valid_out & rsp_ready_out pops the head.
//  - Push into empty queue: head is visible to responses from the next cycle only; no write-to-read bypass.
//  - Simultaneous push and pop when not full and not empty: both occur; pending unchanged.
//  - Pointers: $clog2(MAX_PENDING) bits, natural wrap-around.
//    - full  = (pending == MAX_PENDING)
//    - empty = (pending == 0)
//    - pending += push - pop each cycle; never exceeds MAX_PENDING, never underflows.
//  - rsp_valid_in while empty is a protocol error:
//    - the response is stalled (rsp_ready_in=0);
//    - rsp_error sets the next cycle and holds until reset;
//    - simulation assertion fires.
//  - Reset mid-operation: all outstanding tags discarded. Target must be reset together with this block.
//  - No assertion on stable payload while stalled is required. Outputs follow inputs combinationally.
// STRUCTURE
//  - No shared package typedefs needed. Widths derive from parameters via VX_define.vh macros.
//  - Tag queue is one sub-module: VX_fifo_queue (DATAW=IN_WIDTH, DEPTH=MAX_PENDING, LUTRAM).
//    Its full/empty/size feed the handshake gating above.
//  - Top level: gating logic, pending counter, rsp_error register, assertions.
// TESTING
//  - Reset: hold reset 3 cycles with req_valid_in=1.
//    -> req_ready_in=0, rsp_valid_out=0, pending=0, rsp_error=0 throughout.
//  - In-order tagging: push sel 2,0,3 (ready_out=1), then 3 responses D0..D2.
//    -> rsp_sel_out 2,0,3 paired with D0,D1,D2; pending 3->0.
//  - Full: MAX_PENDING=4, 4 requests, no responses.
//    -> pending=4, req_ready_in=0.
//    -> Fifth request held. One response in the same cycle does not admit it; admitted the next cycle.
//  - Simultaneous push/pop at pending=2 for 10 cycles.
//    -> pending stays 2; sels returned in push order across pointer wrap.
//  - Backpressure: rsp_ready_out=0 for 5 cycles.
//    -> rsp_ready_in=0, head tag stable, pending unchanged; drains in order once released.
//  - Error: rsp_valid_in=1 with empty queue.
//    -> rsp_valid_out=0, rsp_ready_in=0, rsp_error=1 next cycle, held until reset.

Source files
------------

// File: rtl/vx_stream_rsp_tracker_pkg.sv
// Shared sizing constants and helpers for the stream response tracker.
// Default widths and depths live here so the top, its interface and benches agree.
package vx_stream_rsp_tracker_pkg;

    // Width of an index into n items, never narrower than one bit.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_INPUTS  = 4;
    localparam int DEF_IN_WIDTH    = log2up(DEF_NUM_INPUTS);
    localparam int DEF_REQ_DATAW   = 4;
    localparam int DEF_RSP_DATAW   = 4;
    localparam int DEF_MAX_PENDING = 4;
    localparam int DEF_LUTRAM      = 0;

endpackage

// File: rtl/vx_stream_rsp_tracker_if.sv
// Request and response handshake bundle around the tracker.
// The slave modport is the tracker itself; master is the surrounding crossbar/target side.
interface vx_stream_rsp_tracker_if
    import vx_stream_rsp_tracker_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int REQ_DATAW = DEF_REQ_DATAW,
    parameter int RSP_DATAW = DEF_RSP_DATAW
);
    logic                 req_valid_in;
    logic [REQ_DATAW-1:0] req_data_in;
    logic [IN_WIDTH-1:0]  req_sel_in;
    logic                 req_ready_in;
    logic                 req_valid_out;
    logic [REQ_DATAW-1:0] req_data_out;
    logic                 req_ready_out;
    logic                 rsp_valid_in;
    logic [RSP_DATAW-1:0] rsp_data_in;
    logic                 rsp_ready_in;
    logic                 rsp_valid_out;
    logic [RSP_DATAW-1:0] rsp_data_out;
    logic [IN_WIDTH-1:0]  rsp_sel_out;
    logic                 rsp_ready_out;

    modport slave (
        input  req_valid_in, req_data_in, req_sel_in, req_ready_out,
        input  rsp_valid_in, rsp_data_in, rsp_ready_out,
        output req_ready_in, req_valid_out, req_data_out,
        output rsp_ready_in, rsp_valid_out, rsp_data_out, rsp_sel_out
    );

    modport master (
        output req_valid_in, req_data_in, req_sel_in, req_ready_out,
        output rsp_valid_in, rsp_data_in, rsp_ready_out,
        input  req_ready_in, req_valid_out, req_data_out,
        input  rsp_ready_in, rsp_valid_out, rsp_data_out, rsp_sel_out
    );
endinterface

// File: rtl/vx_stream_rsp_tracker_fifo.sv
// In-order tag queue: circular buffer with occupancy count.
// Callers must only push when not full and only pop when not empty.
module vx_stream_rsp_tracker_fifo #(
    parameter int DATAW  = 2,
    parameter int DEPTH  = 4,
    parameter int LUTRAM = 0,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int SIZEW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [SIZEW-1:0] size
);
    logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SIZEW-1:0] size_q, size_d;
    logic [DATAW-1:0] mem_q [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDRW'(push);
        rd_ptr_d = rd_ptr_q + ADDRW'(pop);
        size_d   = size_q + SIZEW'(push) - SIZEW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            size_q   <= size_d;
        end
    end

    // LUTRAM storage cannot be reset; the head is only observed when non-empty anyway.
    if (LUTRAM != 0) begin : g_lutram
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_in;
            end
        end
    end else begin : g_flops
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (push) begin
                mem_q[wr_ptr_q] <= data_in;
            end
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign full     = (size_q == SIZEW'(DEPTH));
    assign empty    = (size_q == '0);
    assign size     = size_q;

endmodule

// File: rtl/vx_stream_rsp_tracker.sv
// Downstream side of a crossbar output: forwards requests, remembers who sent each one,
// and tags the in-order responses with that requester index for the return crossbar.
module vx_stream_rsp_tracker
    import vx_stream_rsp_tracker_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int REQ_DATAW   = DEF_REQ_DATAW,
    parameter int RSP_DATAW   = DEF_RSP_DATAW,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int LUTRAM      = DEF_LUTRAM,
    localparam int IN_WIDTH   = log2up(NUM_INPUTS),
    localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_stream_rsp_tracker_if.slave bus,
    output logic [PEND_W-1:0]     pending,
    output logic                  rsp_error
);
    logic                full;
    logic                empty;
    logic                req_fire;
    logic                rsp_fire;
    logic [IN_WIDTH-1:0] head_sel;
    logic                rsp_error_q, rsp_error_d;

    // Gating uses registered full/empty only, so there is no ready-to-ready path
    // and a pop never frees a slot for a push in the same cycle.
    assign bus.req_valid_out = bus.req_valid_in  & ~full  & ~reset;
    assign bus.req_ready_in  = bus.req_ready_out & ~full  & ~reset;
    assign bus.req_data_out  = bus.req_data_in;
    assign bus.rsp_valid_out = bus.rsp_valid_in  & ~empty & ~reset;
    assign bus.rsp_ready_in  = bus.rsp_ready_out & ~empty & ~reset;
    assign bus.rsp_data_out  = bus.rsp_data_in;
    assign bus.rsp_sel_out   = head_sel;

    assign req_fire = bus.req_valid_in & bus.req_ready_out & ~full  & ~reset;
    assign rsp_fire = bus.rsp_valid_in & bus.rsp_ready_out & ~empty & ~reset;

    vx_stream_rsp_tracker_fifo #(
        .DATAW  (IN_WIDTH),
        .DEPTH  (MAX_PENDING),
        .LUTRAM (LUTRAM)
    ) tag_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (req_fire),
        .pop      (rsp_fire),
        .data_in  (bus.req_sel_in),
        .data_out (head_sel),
        .full     (full),
        .empty    (empty),
        .size     (pending)
    );

    // A response with nothing outstanding means the target lost sync with us.
    always_comb begin
        rsp_error_d = rsp_error_q | (bus.rsp_valid_in & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_error_q <= 1'b0;
        end else begin
            rsp_error_q <= rsp_error_d;
        end
    end

    assign rsp_error = rsp_error_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.rsp_valid_in && empty))
                else $warning("rsp_tracker: response arrived with no outstanding request");
            assert (pending <= PEND_W'(MAX_PENDING))
                else $error("rsp_tracker: pending count out of range");
        end
    end

endmodule

// File: tb/tb_vx_stream_rsp_tracker.sv
// Directed plus randomized bench for vx_stream_rsp_tracker, checked against a queue-based model.
// The model keeps outstanding requester indices in a queue and applies the handshake rules directly.
module tb_vx_stream_rsp_tracker;
    import vx_stream_rsp_tracker_pkg::*;

    localparam int PEND_W = $clog2(DEF_MAX_PENDING + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [PEND_W-1:0] pending;
    logic              rsp_error;

    vx_stream_rsp_tracker_if #(
        .IN_WIDTH  (DEF_IN_WIDTH),
        .REQ_DATAW (DEF_REQ_DATAW),
        .RSP_DATAW (DEF_RSP_DATAW)
    ) bus ();

    vx_stream_rsp_tracker #(
        .NUM_INPUTS  (DEF_NUM_INPUTS),
        .REQ_DATAW   (DEF_REQ_DATAW),
        .RSP_DATAW   (DEF_RSP_DATAW),
        .MAX_PENDING (DEF_MAX_PENDING),
        .LUTRAM      (DEF_LUTRAM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pending   (pending),
        .rsp_error (rsp_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    logic [DEF_IN_WIDTH-1:0] tag_m [$];
    bit                      err_m = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        bit full_m  = (tag_m.size() == DEF_MAX_PENDING);
        bit empty_m = (tag_m.size() == 0);
        check("req_valid_out", 8'(bus.req_valid_out), 8'(!reset && bus.req_valid_in && !full_m));
        check("req_ready_in",  8'(bus.req_ready_in),  8'(!reset && bus.req_ready_out && !full_m));
        check("req_data_out",  8'(bus.req_data_out),  8'(bus.req_data_in));
        check("rsp_valid_out", 8'(bus.rsp_valid_out), 8'(!reset && bus.rsp_valid_in && !empty_m));
        check("rsp_ready_in",  8'(bus.rsp_ready_in),  8'(!reset && bus.rsp_ready_out && !empty_m));
        check("rsp_data_out",  8'(bus.rsp_data_out),  8'(bus.rsp_data_in));
        if (!empty_m && !reset) begin
            check("rsp_sel_out", 8'(bus.rsp_sel_out), 8'(tag_m[0]));
        end
        check("pending",   8'(pending),   8'(tag_m.size()));
        check("rsp_error", 8'(rsp_error), 8'(err_m));
    endtask

    task automatic apply_stimulus(input bit rst, input bit rqv, input logic [DEF_IN_WIDTH-1:0] sel,
                                  input bit rqr, input bit rsv, input bit rsr);
        reset             = rst;
        bus.req_valid_in  = rqv;
        bus.req_data_in   = DEF_REQ_DATAW'($urandom);
        bus.req_sel_in    = sel;
        bus.req_ready_out = rqr;
        bus.rsp_valid_in  = rsv;
        bus.rsp_data_in   = DEF_RSP_DATAW'($urandom);
        bus.rsp_ready_out = rsr;
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic run_cycle();
        bit do_push, do_pop, do_err;
        logic [DEF_IN_WIDTH-1:0] sel;
        @(negedge clk);
        check_outputs();
        do_pop  = !reset && bus.rsp_valid_in && bus.rsp_ready_out && (tag_m.size() != 0);
        do_push = !reset && bus.req_valid_in && bus.req_ready_out && (tag_m.size() != DEF_MAX_PENDING);
        do_err  = !reset && bus.rsp_valid_in && (tag_m.size() == 0);
        sel     = bus.req_sel_in;
        @(posedge clk);
        if (reset) begin
            tag_m.delete();
            err_m = 1'b0;
        end else begin
            if (do_pop)  void'(tag_m.pop_front());
            if (do_push) tag_m.push_back(sel);
            if (do_err)  err_m = 1'b1;
        end
        #1;
    endtask

    function automatic logic [DEF_IN_WIDTH-1:0] rand_sel();
        return DEF_IN_WIDTH'($urandom_range(DEF_NUM_INPUTS - 1, 0));
    endfunction

    initial begin
        // Reset held with traffic offered; first edge establishes a known state.
        apply_stimulus(1, 1, 0, 1, 1, 1);
        @(posedge clk);
        #1;
        repeat (3) run_cycle();

        // In-order tagging: sels 2,0,3 then three responses.
        apply_stimulus(0, 1, 2, 1, 0, 1); run_cycle();
        apply_stimulus(0, 1, 0, 1, 0, 1); run_cycle();
        apply_stimulus(0, 1, 3, 1, 0, 1); run_cycle();
        repeat (3) begin
            apply_stimulus(0, 0, 0, 1, 1, 1);
            run_cycle();
        end

        // Fill to capacity, then offer a fifth request alongside a response.
        repeat (DEF_MAX_PENDING) begin
            apply_stimulus(0, 1, rand_sel(), 1, 0, 1);
            run_cycle();
        end
        apply_stimulus(0, 1, 1, 1, 1, 1); run_cycle();
        apply_stimulus(0, 1, 1, 1, 0, 1); run_cycle();
        repeat (DEF_MAX_PENDING) begin
            apply_stimulus(0, 0, 0, 1, 1, 1);
            run_cycle();
        end

        // Steady push+pop at depth two across several pointer wraps.
        repeat (2) begin
            apply_stimulus(0, 1, rand_sel(), 1, 0, 1);
            run_cycle();
        end
        repeat (10) begin
            apply_stimulus(0, 1, rand_sel(), 1, 1, 1);
            run_cycle();
        end
        repeat (2) begin
            apply_stimulus(0, 0, 0, 1, 1, 1);
            run_cycle();
        end

        // Return-side backpressure, then release.
        repeat (3) begin
            apply_stimulus(0, 1, rand_sel(), 1, 0, 1);
            run_cycle();
        end
        repeat (5) begin
            apply_stimulus(0, 0, 0, 1, 1, 0);
            run_cycle();
        end
        repeat (3) begin
            apply_stimulus(0, 0, 0, 1, 1, 1);
            run_cycle();
        end

        // Random legal traffic: responses only offered while something is outstanding.
        repeat (300) begin
            apply_stimulus(0, 1'($urandom), rand_sel(), 1'($urandom),
                           (tag_m.size() != 0) && 1'($urandom), 1'($urandom));
            run_cycle();
        end
        for (int i = 0; i < DEF_MAX_PENDING; i++) begin
            apply_stimulus(0, 0, 0, 1, tag_m.size() != 0, 1);
            run_cycle();
        end

        // Protocol error: response with an empty queue, sticky until reset.
        apply_stimulus(0, 0, 0, 1, 1, 1); run_cycle();
        repeat (3) begin
            apply_stimulus(0, 1, rand_sel(), 1, 0, 1);
            run_cycle();
        end
        repeat (2) begin
            apply_stimulus(1, 1, rand_sel(), 1, 0, 1);
            run_cycle();
        end
        repeat (3) begin
            apply_stimulus(0, 1, rand_sel(), 1, 0, 1);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
